// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose next state is applied through per-bit J/K excitation.
// Optional: define JK_COUNTER_SATURATE_EN to hold at the boundary instead of wrapping.
module jk_mod_counter_bit (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic [7:0]       wrap_cnt
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
`ifdef JK_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic [WIDTH-1:0] nxt;
  logic             bnd_step;

  always_comb begin
    nxt      = count;
    bnd_step = 1'b0;
    if (load) begin
      nxt = (load_val > MAX) ? MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (count == MAX) begin
          bnd_step = 1'b1;
          nxt      = SAT ? count : '0;
        end else nxt = count + 1'b1;
      end else begin
        if (count == '0) begin
          bnd_step = 1'b1;
          nxt      = SAT ? count : MAX;
        end else nxt = count - 1'b1;
      end
    end
  end

  assign j = ~count & nxt;
  assign k = count & ~nxt;

  // One JK cell per bit; the bank as a whole lands on nxt every edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_mod_counter_bit u_bit (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (count[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc       <= 1'b0;
      wrap_cnt <= 8'h00;
    end else begin
      tc <= bnd_step;
      if (bnd_step && wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'h01;
    end
  end
endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: arithmetic reference model checked every cycle plus directed literals.
module tb_jk_mod_counter;
  localparam int W = 4;
  localparam int M = 10;
`ifdef JK_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] j, k, count;
  logic         tc;
  logic [7:0]   wrap_cnt;

  int  nchecks = 0;
  int  nerr    = 0;
  bit  chk_on  = 1'b0;

  int  m_count = 0;
  bit  m_tc    = 1'b0;
  int  m_wrap  = 0;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .j(j), .k(k), .count(count), .tc(tc), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mstep(input int c, input bit ld, input int lv, input bit e,
                                input bit u, output int n, output bit w);
    n = c;
    w = 1'b0;
    if (ld) n = (lv >= M) ? M - 1 : lv;
    else if (e) begin
      if (u) begin w = (c == M - 1); n = (c + 1) % M; end
      else   begin w = (c == 0);     n = (c + M - 1) % M; end
      if (w && SAT) n = c;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    int  n;
    bit  w;
    if (rst) begin
      m_count <= 0;
      m_tc    <= 1'b0;
      m_wrap  <= 0;
    end else begin
      mstep(m_count, load, int'(load_val), en, up, n, w);
      m_count <= n;
      m_tc    <= w;
      if (w && m_wrap < 255) m_wrap <= m_wrap + 1;
    end
  end

  // Per-cycle comparison; j/k expected from bit transitions between current and next value.
  always @(negedge clk) begin
    int  n;
    bit  w;
    int  ej, ek;
    if (chk_on) begin
      mstep(m_count, load, int'(load_val), en, up, n, w);
      ej = 0;
      ek = 0;
      for (int i = 0; i < W; i++) begin
        if (((n >> i) & 1) == 1 && ((m_count >> i) & 1) == 0) ej += (1 << i);
        if (((n >> i) & 1) == 0 && ((m_count >> i) & 1) == 1) ek += (1 << i);
      end
      chk("cyc_count", int'(count), m_count);
      chk("cyc_tc", int'(tc), int'(m_tc));
      chk("cyc_wrap", int'(wrap_cnt), m_wrap);
      chk("cyc_j", int'(j), ej);
      chk("cyc_k", int'(k), ek);
    end
  end

  task automatic drive(input bit ld, input int lv, input bit e, input bit u);
    load = ld; load_val = W'(lv); en = e; up = u;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    clocks(2);
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_tc", int'(tc), 0);
    chk("rst_wrap", int'(wrap_cnt), 0);
    chk("rst_jk", int'({j, k}), 0);

    drive(0, 0, 1, 1);
    clocks(9);
    chk("up9_count", int'(count), 9);
    chk("up9_tc", int'(tc), 0);
`ifndef JK_COUNTER_SATURATE_EN
    chk("wrap_j", int'(j), 4'b0000);
    chk("wrap_k", int'(k), 4'b1001);
    clocks(1);
    chk("wrap_count", int'(count), 0);
    chk("wrap_tc", int'(tc), 1);
    chk("wrap_cnt1", int'(wrap_cnt), 1);

    drive(0, 0, 1, 0);
    #1;
    chk("down_j", int'(j), 4'b1001);
    chk("down_k", int'(k), 4'b0000);
    clocks(1);
    chk("down_count", int'(count), 9);
    chk("down_tc", int'(tc), 1);
    chk("down_wrap", int'(wrap_cnt), 2);

    drive(1, 13, 1, 1);
    clocks(1);
    chk("clamp_count", int'(count), 9);
    chk("clamp_tc", int'(tc), 0);
    chk("clamp_wrap", int'(wrap_cnt), 2);

    drive(1, 0, 0, 0);
    clocks(1);
    drive(1, 5, 0, 0);
    #1;
    chk("load5_j", int'(j), 4'b0101);
    chk("load5_k", int'(k), 4'b0000);
    clocks(1);
    chk("load5_count", int'(count), 5);
`else
    clocks(3);
    chk("sat_count", int'(count), 9);
    chk("sat_tc", int'(tc), 1);
    chk("sat_wrap3", int'(wrap_cnt), 3);
    chk("sat_jk", int'({j, k}), 0);
    clocks(300);
    chk("sat_wrap255", int'(wrap_cnt), 255);
    chk("sat_count2", int'(count), 9);
    drive(1, 0, 0, 0);
    clocks(1);
    drive(0, 0, 1, 0);
    clocks(1);
    chk("sat_down_count", int'(count), 0);
    chk("sat_down_tc", int'(tc), 1);
`endif

    drive(1, 3, 0, 0);
    clocks(1);
    drive(0, 0, 0, 1);
    #1;
    chk("hold_jk", int'({j, k}), 0);
    clocks(5);
    chk("hold_count", int'(count), 3);
    chk("hold_tc", int'(tc), 0);

    drive(0, 0, 1, 1);
    clocks(4);
    chk("pre_rst_count", int'(count), 7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_tc", int'(tc), 0);
    chk("async_wrap", int'(wrap_cnt), 0);
    clocks(2);
    rst = 1'b0;
    clocks(1);
    chk("post_rst_count", int'(count), 1);

    drive(1, 15, 0, 0);
    clocks(1);
    chk("clamp15_count", int'(count), 9);
    drive(0, 0, 1, 0);
    clocks(12);
    chk("down_run_count", int'(count), SAT ? 0 : 7);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
